// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - multi-cycle execute/write-back stage for an 8x8 register file
// Optional shift-add multiplier for opcode 111 is built only when ALU_MUL_EN is defined.
module alu_exec_stage #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    opcode,
  input  logic [AW-1:0] rd,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  output logic [AW-1:0] RX,
  output logic [AW-1:0] RY,
  input  logic [DW-1:0] busX,
  input  logic [DW-1:0] busY,
  output logic          WEN,
  output logic [AW-1:0] RW,
  output logic [DW-1:0] busW,
  output logic          flag_z,
  output logic          flag_c,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] rx_q, rx_d;
  logic [AW-1:0] ry_q, ry_d;
  logic [DW-1:0] opa_q, opa_d;
  logic [DW-1:0] opb_q, opb_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] rw_q, rw_d;
  logic [DW-1:0] busw_q, busw_d;
  logic          carry_q, carry_d;
  logic          flag_z_q, flag_z_d;
  logic          flag_c_q, flag_c_d;

  logic [DW:0]   alu_ext;
  logic [DW-1:0] alu_res;
  logic          alu_c;

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(DW);
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*DW-1:0] acc_q, acc_d;
  logic [2*DW-1:0] mcand_q, mcand_d;
  logic [DW-1:0]   mplier_q, mplier_d;
  logic [2*DW-1:0] mul_sum;
`endif

  // Single-cycle operations; MUL is handled by the iterative path below.
  always_comb begin
    alu_ext = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      3'b000: begin
        alu_ext = {1'b0, opa_q} + {1'b0, opb_q};
        alu_res = alu_ext[DW-1:0];
        alu_c   = alu_ext[DW];
      end
      3'b001: begin
        alu_ext = {1'b0, opa_q} - {1'b0, opb_q};
        alu_res = alu_ext[DW-1:0];
        alu_c   = alu_ext[DW];
      end
      3'b010:  alu_res = opa_q & opb_q;
      3'b011:  alu_res = opa_q | opb_q;
      3'b100:  alu_res = opa_q ^ opb_q;
      3'b101:  alu_res = opa_q << opb_q[2:0];
      3'b110:  alu_res = opa_q >> opb_q[2:0];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rx_d     = rx_q;
    ry_d     = ry_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    wen_d    = 1'b0;
    rw_d     = rw_q;
    busw_d   = busw_q;
    carry_d  = carry_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
`ifdef ALU_MUL_EN
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          op_d    = opcode;
          rd_d    = rd;
          rx_d    = rs;
          ry_d    = rt;
          state_d = READ;
        end
      end
      READ: begin
        opa_d   = busX;
        opb_d   = busY;
`ifdef ALU_MUL_EN
        cnt_d    = '0;
        acc_d    = '0;
        mcand_d  = {{DW{1'b0}}, busX};
        mplier_d = busY;
`endif
        state_d = EXEC;
      end
      EXEC: begin
        if (op_q == 3'b111) begin
`ifdef ALU_MUL_EN
          acc_d    = mul_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CW'(DW - 1)) begin
            busw_d  = mul_sum[DW-1:0];
            carry_d = |mul_sum[2*DW-1:DW];
            wen_d   = 1'b1;
            rw_d    = rd_q;
            state_d = WB;
          end
`else
          // Without the multiplier, MUL retires silently: no write, flags kept.
          state_d = IDLE;
`endif
        end else begin
          busw_d  = alu_res;
          carry_d = alu_c;
          wen_d   = 1'b1;
          rw_d    = rd_q;
          state_d = WB;
        end
      end
      WB: begin
        flag_z_d = (busw_q == '0);
        flag_c_d = carry_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      rx_q     <= '0;
      ry_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      wen_q    <= 1'b0;
      rw_q     <= '0;
      busw_q   <= '0;
      carry_q  <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
`ifdef ALU_MUL_EN
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rx_q     <= rx_d;
      ry_q     <= ry_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      wen_q    <= wen_d;
      rw_q     <= rw_d;
      busw_q   <= busw_d;
      carry_q  <= carry_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
`ifdef ALU_MUL_EN
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

  assign instr_ready = Rst_n && (state_q == IDLE);
  assign busy        = Rst_n && (state_q != IDLE);
  assign RX          = rx_q;
  assign RY          = ry_q;
  assign WEN         = wen_q;
  assign RW          = rw_q;
  assign busW        = busw_q;
  assign flag_z      = flag_z_q;
  assign flag_c      = flag_c_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - randomized self-checking bench for alu_exec_stage
// Models the register file and checks each instruction against an arithmetic reference.
module tb_alu_exec_stage;
  localparam int DW = 8;
  localparam int AW = 3;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    opcode;
  logic [AW-1:0] rd, rs, rt;
  logic [AW-1:0] RX, RY, RW;
  logic [DW-1:0] busX, busY, busW;
  logic          WEN, flag_z, flag_c, busy;

  logic [DW-1:0] rf [8];
  logic [DW-1:0] exp_rf [8];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  logic          ef_z, ef_c;

  int n_checks = 0;
  int n_pass = 0;

  alu_exec_stage #(.DW(DW), .AW(AW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .RX(RX), .RY(RY),
    .busX(busX), .busY(busY), .WEN(WEN), .RW(RW), .busW(busW),
    .flag_z(flag_z), .flag_c(flag_c), .busy(busy)
  );

  always #5 Clk = ~Clk;

  assign busX = rf[RX];
  assign busY = rf[RY];

  always @(posedge Clk) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (WEN && RW != 0) rf[RW] <= busW;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void model(input logic [2:0] op, input int a, input int b,
                                output int res, output int c, output bit wr);
    wr = 1'b1;
    c  = 0;
    case (op)
      3'd0: begin res = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
      3'd1: begin res = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: res = (a << (b % 8)) % 256;
      3'd6: res = a >> (b % 8);
      default: begin
        res = (a * b) % 256;
        c = (a * b > 255) ? 1 : 0;
`ifndef ALU_MUL_EN
        wr = 1'b0;
`endif
      end
    endcase
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(negedge Clk);
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    @(negedge Clk);
    pl_en = 1'b0;
    exp_rf[a] = v;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !instr_ready; i++) @(negedge Clk);
    check("ready_wait", 32'(instr_ready), 32'd1);
  endtask

  task automatic run_instr(input logic [2:0] op, input logic [AW-1:0] d,
                           input logic [AW-1:0] s, input logic [AW-1:0] t);
    int res, c, lat, wen_cnt, wen_k, ready_k;
    bit wr;
    logic [AW-1:0] w_rw;
    logic [DW-1:0] w_busw;
    model(op, int'(exp_rf[s]), int'(exp_rf[t]), res, c, wr);
    lat = 3;
`ifdef ALU_MUL_EN
    if (op == 3'd7) lat = 2 + DW;
`endif
    wait_ready();
    instr_valid = 1'b1; opcode = op; rd = d; rs = s; rt = t;
    @(posedge Clk); #1;
    instr_valid = 1'b0;
    wen_cnt = 0; wen_k = 0; ready_k = 0; w_rw = '0; w_busw = '0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge Clk);
      if (k == 1) begin
        check("rx", 32'(RX), 32'(s));
        check("ry", 32'(RY), 32'(t));
        check("busy", 32'(busy), 32'd1);
      end
      if (WEN) begin wen_cnt++; wen_k = k; w_rw = RW; w_busw = busW; end
      if (instr_ready && ready_k == 0) ready_k = k;
    end
    if (wr) begin
      check("wen_count", 32'(wen_cnt), 32'd1);
      check("wen_cycle", 32'(wen_k), 32'(lat));
      check("rw", 32'(w_rw), 32'(d));
      check("busw", 32'(w_busw), 32'(res));
      check("ready_cycle", 32'(ready_k), 32'(lat + 1));
      if (d != 0) exp_rf[d] = 8'(res);
      ef_z = (res == 0);
      ef_c = (c != 0);
    end else begin
      check("wen_count", 32'(wen_cnt), 32'd0);
      check("ready_cycle", 32'(ready_k), 32'd3);
    end
    check("flag_z", 32'(flag_z), 32'(ef_z));
    check("flag_c", 32'(flag_c), 32'(ef_c));
    check("rf_dest", 32'(rf[d]), 32'(exp_rf[d]));
  endtask

  task automatic reset_mid_mul();
    wait_ready();
    instr_valid = 1'b1; opcode = 3'd7; rd = 3'd5; rs = 3'd1; rt = 3'd2;
    @(posedge Clk); #1;
    instr_valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check("rst_wen", 32'(WEN), 32'd0);
    check("rst_rx", 32'(RX), 32'd0);
    check("rst_ry", 32'(RY), 32'd0);
    check("rst_rw", 32'(RW), 32'd0);
    check("rst_busw", 32'(busW), 32'd0);
    check("rst_flags", {30'd0, flag_z, flag_c}, 32'd0);
    check("rst_ready", 32'(instr_ready), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(instr_ready), 32'd1);
    ef_z = 1'b0; ef_c = 1'b0;
    for (int i = 0; i < 8; i++) check("rf_unchanged", 32'(rf[i]), 32'(exp_rf[i]));
  endtask

  task automatic back_to_back();
    wait_ready();
    instr_valid = 1'b1; opcode = 3'd0; rd = 3'd1; rs = 3'd1; rt = 3'd1;
    @(posedge Clk); #1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge Clk);
      check("b2b_ready", 32'(instr_ready), (k == 4) ? 32'd1 : 32'd0);
      if (k == 3) check("b2b_first_wr", {23'd0, WEN, busW}, {23'd0, 1'b1, 8'h06});
    end
    @(posedge Clk); #1;
    instr_valid = 1'b0;
    for (int k = 5; k <= 8; k++) begin
      @(negedge Clk);
      check("b2b_wen", 32'(WEN), (k == 7) ? 32'd1 : 32'd0);
      if (k == 7) begin
        check("b2b_busw", 32'(busW), 32'h0C);
        check("b2b_rw", 32'(RW), 32'd1);
      end
    end
    exp_rf[1] = 8'h0C;
    ef_z = 1'b0; ef_c = 1'b0;
    check("b2b_rf", 32'(rf[1]), 32'h0C);
    check("b2b_flags", {30'd0, flag_z, flag_c}, 32'd0);
  endtask

  initial begin
    Rst_n = 1'b0; instr_valid = 1'b0; opcode = '0; rd = '0; rs = '0; rt = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    ef_z = 1'b0; ef_c = 1'b0;
    for (int i = 0; i < 8; i++) exp_rf[i] = '0;
    repeat (2) @(negedge Clk);
    check("reset_ready", 32'(instr_ready), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_outs", {15'd0, WEN, RX, RY, RW, busW}, 32'd0);
    check("reset_flags", {30'd0, flag_z, flag_c}, 32'd0);
    Rst_n = 1'b1;
    @(negedge Clk);
    check("idle_ready", 32'(instr_ready), 32'd1);

    for (int i = 0; i < 8; i++) preload(3'(i), 8'(i * 17));
    preload(3'd0, 8'h00);
    preload(3'd1, 8'hF0);
    preload(3'd2, 8'h20);
    run_instr(3'd0, 3'd3, 3'd1, 3'd2);
    run_instr(3'd1, 3'd4, 3'd2, 3'd1);
    run_instr(3'd4, 3'd5, 3'd1, 3'd1);
    preload(3'd1, 8'h10);
    run_instr(3'd7, 3'd5, 3'd1, 3'd2);
    run_instr(3'd0, 3'd6, 3'd0, 3'd2);
    run_instr(3'd0, 3'd0, 3'd2, 3'd2);
    check("r0_zero", 32'(rf[0]), 32'd0);
    preload(3'd1, 8'hF0);
    run_instr(3'd0, 3'd3, 3'd1, 3'd2);
    preload(3'd1, 8'h10);
    reset_mid_mul();
    preload(3'd1, 8'h03);
    back_to_back();

    for (int n = 0; n < 48; n++) begin
      if (n % 6 == 0) preload(3'($urandom_range(1, 7)), 8'($urandom));
      run_instr(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
